// File: rtl/rvv_reduction_unit.sv
// rvv_reduction_unit: RISC-V vector reduction engine (vred*).
// Folds NB_LANES elements of a captured source vector into a scalar
// accumulator each RUN beat. The arithmetic is done at SEW width, and
// masking and vl clamping are applied per element.

// One reduction lane: picks element (base_idx + LANE), decides whether it
// is active, and folds it into the incoming partial accumulator.
module rvv_reduction_unit_lane #(
  parameter int VLEN = 128,
  parameter int LANE = 0
) (
  input  logic [2:0]      i_funct,
  input  logic [1:0]      i_sew,
  input  logic [16:0]     i_base_idx,
  input  logic [16:0]     i_eff_vl,
  input  logic            i_vm,
  input  logic [VLEN-1:0] i_v0,
  input  logic [VLEN-1:0] i_vs2,
  input  logic [31:0]     i_acc,
  output logic [31:0]     o_acc
);
  localparam int IW8  = $clog2(VLEN/8);
  localparam int IW16 = $clog2(VLEN/16);
  localparam int IW32 = $clog2(VLEN/32);
  localparam int IWV  = $clog2(VLEN);

  logic [16:0]                w_idx;
  logic [VLEN/8-1:0][7:0]     w_v8;
  logic [VLEN/16-1:0][15:0]   w_v16;
  logic [VLEN/32-1:0][31:0]   w_v32;
  logic [31:0]                w_elem, w_mask, w_sa, w_sb, w_res;
  logic                       w_act, w_lts, w_ltu;

  assign w_idx = i_base_idx + 17'(LANE);
  assign w_v8  = i_vs2;
  assign w_v16 = i_vs2;
  assign w_v32 = i_vs2;

  // Out-of-range indices wrap in the select below, but such lanes are
  // always inactive because eff_vl never exceeds VLEN/SEW.
  assign w_act = (w_idx < i_eff_vl) && (i_vm || i_v0[w_idx[IWV-1:0]]);

  // Element extraction and SEW-dependent mask / sign extension
  always_comb begin
    w_elem = '0;
    w_mask = 32'hFFFF_FFFF;
    w_sa   = i_acc;
    w_sb   = '0;
    case (i_sew)
      2'd0: begin
        w_elem = {24'b0, w_v8[w_idx[IW8-1:0]]};
        w_mask = 32'h0000_00FF;
        w_sa   = {{24{i_acc[7]}}, i_acc[7:0]};
        w_sb   = {{24{w_elem[7]}}, w_elem[7:0]};
      end
      2'd1: begin
        w_elem = {16'b0, w_v16[w_idx[IW16-1:0]]};
        w_mask = 32'h0000_FFFF;
        w_sa   = {{16{i_acc[15]}}, i_acc[15:0]};
        w_sb   = {{16{w_elem[15]}}, w_elem[15:0]};
      end
      default: begin
        w_elem = w_v32[w_idx[IW32-1:0]];
        w_sb   = w_elem;
      end
    endcase
  end

  assign w_lts = $signed(w_sa) < $signed(w_sb);
  assign w_ltu = i_acc < w_elem;

  // Combine accumulator with element; both operands are already zero-extended SEW values
  always_comb begin
    w_res = i_acc;
    case (i_funct)
      3'b000: w_res = (i_acc + w_elem) & w_mask;
      3'b001: w_res = i_acc & w_elem;
      3'b010: w_res = i_acc | w_elem;
      3'b011: w_res = i_acc ^ w_elem;
      3'b100: w_res = w_ltu ? i_acc : w_elem;
      3'b101: w_res = w_lts ? i_acc : w_elem;
      3'b110: w_res = w_ltu ? w_elem : i_acc;
      default: w_res = w_lts ? w_elem : i_acc;
    endcase
  end

  assign o_acc = w_act ? w_res : i_acc;
endmodule

module rvv_reduction_unit #(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [2:0]      funct,
  input  logic [2:0]      vsew,
  input  logic [16:0]     vl,
  input  logic            vm,
  input  logic [VLEN-1:0] v0,
  input  logic [31:0]     vs1_scalar,
  input  logic [VLEN-1:0] vs2,
  output logic            busy,
  output logic            done,
  output logic [31:0]     result,
  output logic            instr_valid
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                   r_state;
  logic [2:0]               r_funct;
  logic [1:0]               r_sew;
  logic                     r_vm;
  logic [VLEN-1:0]          r_v0, r_vs2;
  logic [16:0]              r_eff_vl, r_idx;
  logic [31:0]              r_acc, r_result;
  logic                     r_busy, r_done, r_valid;

  logic [16:0]              w_max_el, w_eff_vl;
  logic [31:0]              w_vs1m;
  logic                     w_vsew_ok, w_last;
  logic [NB_LANES:0][31:0]  w_chain;

  assign w_vsew_ok = (vsew <= 3'd2);

  // Capacity of the register at the requested SEW and the vs1 low-SEW value
  always_comb begin
    w_max_el = 17'(VLEN/32);
    w_vs1m   = vs1_scalar;
    case (vsew)
      3'd0: begin
        w_max_el = 17'(VLEN/8);
        w_vs1m   = {24'b0, vs1_scalar[7:0]};
      end
      3'd1: begin
        w_max_el = 17'(VLEN/16);
        w_vs1m   = {16'b0, vs1_scalar[15:0]};
      end
      default: ;
    endcase
  end

  assign w_eff_vl = (vl < w_max_el) ? vl : w_max_el;

  // Lanes are chained: each folds its element onto the previous lane's partial
  assign w_chain[0] = r_acc;
  for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
    rvv_reduction_unit_lane #(.VLEN(VLEN), .LANE(l)) u_lane (
      .i_funct    (r_funct),
      .i_sew      (r_sew),
      .i_base_idx (r_idx),
      .i_eff_vl   (r_eff_vl),
      .i_vm       (r_vm),
      .i_v0       (r_v0),
      .i_vs2      (r_vs2),
      .i_acc      (w_chain[l]),
      .o_acc      (w_chain[l+1])
    );
  end

  assign w_last = ({1'b0, r_idx} + 18'(NB_LANES)) >= {1'b0, r_eff_vl};

  // Control FSM; done/result/instr_valid are registered on entry to FIN
  // so they are visible during the FIN cycle itself.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_funct  <= '0;
      r_sew    <= '0;
      r_vm     <= 1'b0;
      r_v0     <= '0;
      r_vs2    <= '0;
      r_eff_vl <= '0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_funct  <= funct;
            r_sew    <= vsew[1:0];
            r_vm     <= vm;
            r_v0     <= v0;
            r_vs2    <= vs2;
            r_eff_vl <= w_eff_vl;
            r_idx    <= '0;
            r_acc    <= w_vs1m;
            if (!w_vsew_ok) begin
              r_state  <= FIN;
              r_done   <= 1'b1;
              r_result <= '0;
              r_valid  <= 1'b0;
            end else if (w_eff_vl == '0) begin
              r_state  <= FIN;
              r_done   <= 1'b1;
              r_result <= w_vs1m;
              r_valid  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_acc <= w_chain[NB_LANES];
          r_idx <= r_idx + 17'(NB_LANES);
          if (w_last) begin
            r_state  <= FIN;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_result <= w_chain[NB_LANES];
            r_valid  <= 1'b1;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign instr_valid = r_valid;
endmodule

// File: tb/tb_rvv_reduction_unit.sv
// Directed bench for rvv_reduction_unit (VLEN=128, NB_LANES=4).
module tb_rvv_reduction_unit;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   funct = '0;
  logic [2:0]   vsew = '0;
  logic [16:0]  vl = '0;
  logic         vm = 1'b1;
  logic [127:0] v0 = '0;
  logic [31:0]  vs1_scalar = '0;
  logic [127:0] vs2 = '0;
  logic         busy, done, instr_valid;
  logic [31:0]  result;

  int n_vec = 0;
  int n_err = 0;

  rvv_reduction_unit #(.VLEN(128), .NB_LANES(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .funct(funct), .vsew(vsew),
    .vl(vl), .vm(vm), .v0(v0), .vs1_scalar(vs1_scalar), .vs2(vs2),
    .busy(busy), .done(done), .result(result), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // Bytes 1..16 at SEW=8
  function automatic logic [127:0] seq8();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(i + 1);
    return v;
  endfunction

  // Issue one operation starting at the current negedge; returns the number
  // of negedges until done was seen (-1 if never), plus result/instr_valid.
  // Inputs are scrambled right after capture to show they are not re-read.
  task automatic run_op(input logic [2:0] f, input logic [2:0] sew, input logic [16:0] len,
                        input logic m, input logic [127:0] mask, input logic [31:0] s1,
                        input logic [127:0] v, output int lat, output logic [31:0] res,
                        output logic ok);
    funct = f; vsew = sew; vl = len; vm = m; v0 = mask; vs1_scalar = s1; vs2 = v;
    start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; funct = ~f; vsew = 3'd0; vl = 17'd0; vm = ~m;
        v0 = ~mask; vs1_scalar = ~s1; vs2 = ~v;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    res = result;
    ok  = instr_valid;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sum();
    int lat; logic [31:0] r; logic ok;
    @(negedge clk);
    run_op(3'b000, 3'd0, 17'd16, 1'b1, '0, 32'd5, seq8(), lat, r, ok);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL sum8_latency: got %0d want 5", lat); end
    n_vec++; if (r !== 32'h8D || ok !== 1'b1) begin n_err++; $display("FAIL sum8_result: got %h/%b want 0000008d/1", r, ok); end
    @(negedge clk);
    run_op(3'b000, 3'd1, 17'd2, 1'b1, '0, 32'h0000_FFFF, {96'h0, 32'h0001_0001}, lat, r, ok);
    n_vec++; if (lat !== 2 || r !== 32'h1) begin n_err++; $display("FAIL sum16_wrap: got %0d/%h want 2/00000001", lat, r); end
    @(negedge clk);
    run_op(3'b000, 3'd2, 17'd4, 1'b1, '0, 32'h0,
           {32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'd7}, lat, r, ok);
    n_vec++; if (r !== 32'h8000_0009) begin n_err++; $display("FAIL sum32_wrap: got %h want 80000009", r); end
  endtask

  task automatic test_minmax();
    int lat; logic [31:0] r; logic ok;
    logic [127:0] v32, v8;
    v32 = {32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'd7};
    @(negedge clk);
    run_op(3'b101, 3'd2, 17'd4, 1'b1, '0, 32'h0, v32, lat, r, ok);
    n_vec++; if (lat !== 2 || r !== 32'h8000_0000) begin n_err++; $display("FAIL min32: got %0d/%h want 2/80000000", lat, r); end
    @(negedge clk);
    run_op(3'b100, 3'd2, 17'd4, 1'b1, '0, 32'h0, v32, lat, r, ok);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL minu32: got %h want 00000000", r); end
    @(negedge clk);
    run_op(3'b111, 3'd2, 17'd4, 1'b1, '0, 32'h0, v32, lat, r, ok);
    n_vec++; if (r !== 32'h7) begin n_err++; $display("FAIL max32: got %h want 00000007", r); end
    @(negedge clk);
    run_op(3'b110, 3'd2, 17'd4, 1'b1, '0, 32'h0, v32, lat, r, ok);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL maxu32: got %h want ffffffff", r); end
    @(negedge clk);
    run_op(3'b001, 3'd2, 17'd4, 1'b1, '0, 32'hFFFF_FFFF, v32, lat, r, ok);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL and32: got %h want 00000000", r); end
    @(negedge clk);
    run_op(3'b011, 3'd2, 17'd4, 1'b1, '0, 32'h0, v32, lat, r, ok);
    n_vec++; if (r !== 32'h7FFF_FFFB) begin n_err++; $display("FAIL xor32: got %h want 7ffffffb", r); end
    // SEW=8 signed boundary: 0x80 is -128, 0x7F is +127
    v8 = {96'h0, 32'h0001_7F80};
    @(negedge clk);
    run_op(3'b111, 3'd0, 17'd4, 1'b1, '0, 32'h1, v8, lat, r, ok);
    n_vec++; if (r !== 32'h7F) begin n_err++; $display("FAIL max8: got %h want 0000007f", r); end
    @(negedge clk);
    run_op(3'b101, 3'd0, 17'd4, 1'b1, '0, 32'h1, v8, lat, r, ok);
    n_vec++; if (r !== 32'h80) begin n_err++; $display("FAIL min8: got %h want 00000080", r); end
  endtask

  task automatic test_mask();
    int lat; logic [31:0] r; logic ok;
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'(1 << i);
    for (int f = 0; f < 8; f++) begin
      @(negedge clk);
      run_op(3'(f), 3'd1, 17'd8, 1'b0, '0, 32'hFFFF_1234, v, lat, r, ok);
      n_vec++;
      if (lat !== 3 || r !== 32'h1234) begin
        n_err++; $display("FAIL allmasked_f%0d: got %0d/%h want 3/00001234", f, lat, r);
      end
    end
    @(negedge clk);
    run_op(3'b010, 3'd1, 17'd8, 1'b0, 128'h05, 32'h0, v, lat, r, ok);
    n_vec++; if (r !== 32'h5) begin n_err++; $display("FAIL mask_or: got %h want 00000005", r); end
  endtask

  task automatic test_short();
    int lat; logic [31:0] r; logic ok;
    @(negedge clk);
    run_op(3'b000, 3'd0, 17'd0, 1'b1, '0, 32'h1234_ABCD, seq8(), lat, r, ok);
    n_vec++; if (lat !== 1 || r !== 32'hCD || ok !== 1'b1) begin n_err++; $display("FAIL vl0: got %0d/%h/%b want 1/000000cd/1", lat, r, ok); end
    @(negedge clk);
    run_op(3'b000, 3'd3, 17'd16, 1'b1, '0, 32'h1234_ABCD, seq8(), lat, r, ok);
    n_vec++; if (lat !== 1 || r !== 32'h0 || ok !== 1'b0) begin n_err++; $display("FAIL badsew: got %0d/%h/%b want 1/00000000/0", lat, r, ok); end
  endtask

  task automatic test_clamp_ignore();
    int lat; logic busy_ok; logic [31:0] r;
    @(negedge clk);
    funct = 3'b000; vsew = 3'd0; vl = 17'd200; vm = 1'b1; v0 = '0; vs1_scalar = 32'd5; vs2 = seq8();
    start = 1'b1;
    lat = -1; busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; vs2 = '1; vs1_scalar = '0; end
      if (k == 2) begin start = 1'b1; funct = 3'b001; vl = 17'd1; end
      if (k == 3) start = 1'b0;
      if (k >= 1 && k <= 4 && busy !== 1'b1) busy_ok = 1'b0;
      if (done) begin lat = k; break; end
    end
    r = result;
    n_vec++; if (lat !== 5 || r !== 32'h8D) begin n_err++; $display("FAIL clamp_vl200: got %0d/%h want 5/0000008d", lat, r); end
    n_vec++; if (busy_ok !== 1'b1) begin n_err++; $display("FAIL busy_during_run: got %b want 1", busy_ok); end
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL restart_ignored: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midrun();
    int lat; logic [31:0] r; logic ok; logic saw_done;
    @(negedge clk);
    funct = 3'b000; vsew = 3'd0; vl = 17'd16; vm = 1'b1; vs1_scalar = 32'd5; vs2 = seq8();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrun_reset: busy/done got %b/%b want 0/0", busy, done); end
    n_vec++; if (result !== 32'h0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL midrun_reset_out: got %h/%b want 00000000/0", result, instr_valid); end
    @(negedge clk);
    resetn = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin @(negedge clk); if (done) saw_done = 1'b1; end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    run_op(3'b000, 3'd0, 17'd4, 1'b1, '0, 32'h0, {96'h0, 32'h0101_0101}, lat, r, ok);
    n_vec++; if (lat !== 2 || r !== 32'h4) begin n_err++; $display("FAIL after_reset_sum: got %0d/%h want 2/00000004", lat, r); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] r; logic ok;
    @(negedge clk);
    run_op(3'b010, 3'd0, 17'd4, 1'b1, '0, 32'h0, {96'h0, 32'h0804_0201}, lat, r, ok);
    n_vec++; if (lat !== 2 || r !== 32'h0F) begin n_err++; $display("FAIL b2b_first: got %0d/%h want 2/0000000f", lat, r); end
    // Start during the FIN (done) cycle must be dropped
    funct = 3'b000; vsew = 3'd0; vl = 17'd4; vm = 1'b1; vs1_scalar = 32'h10; vs2 = seq8();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL fin_start_ignored: busy/done got %b/%b want 0/0", busy, done); end
    n_vec++; if (result !== 32'h0F) begin n_err++; $display("FAIL result_hold: got %h want 0000000f", result); end
    // Start in the cycle after done is accepted
    run_op(3'b000, 3'd0, 17'd4, 1'b1, '0, 32'h10, seq8(), lat, r, ok);
    n_vec++; if (lat !== 2 || r !== 32'h1A) begin n_err++; $display("FAIL b2b_second: got %0d/%h want 2/0000001a", lat, r); end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_minmax();
    test_mask();
    test_short();
    test_clamp_ignore();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rvv_reduction_unit.md
RVV_REDUCTION_UNIT -- requirements
Module: rvv_reduction_unit

Interface
REQ-001 SHALL have parameter VLEN, default 128: vector register width in bits, a power of two from 64 to 65536.
REQ-002 SHALL have parameter NB_LANES, default 4: number of elements consumed per beat, a power of two from 1 to 16.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a reduction.
REQ-006 SHALL have port funct, input, 3: operation select; 000 sum, 001 and, 010 or, 011 xor, 100 minu, 101 min, 110 maxu, 111 max.
REQ-007 SHALL have port vsew, input, 3: element width select; 000 = 8, 001 = 16, 010 = 32 bits; other values are invalid.
REQ-008 SHALL have port vl, input, 17: requested element count.
REQ-009 SHALL have port vm, input, 1: 1 = unmasked; 0 = element i is active only when v0[i] = 1.
REQ-010 SHALL have port v0, input, VLEN: mask register.
REQ-011 SHALL have port vs1_scalar, input, 32: initial accumulator; only the low SEW bits are used.
REQ-012 SHALL have port vs2, input, VLEN: source vector, with element i at bits [i*SEW +: SEW].
REQ-013 SHALL have port busy, output, 1: high while a reduction is in progress.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port result, output, 32: the SEW-bit result, zero-extended to 32 bits.
REQ-016 SHALL have port instr_valid, output, 1: qualifies result; 0 when vsew was invalid.

Function
REQ-017 SHALL run a state machine with states IDLE, RUN and FIN.
REQ-018 In IDLE, start=1 SHALL capture funct, vsew, vm, v0, vs2 and vs1_scalar into internal registers, set busy, and enter RUN; start in any other state SHALL be ignored.
REQ-019 SHALL set the effective length eff_vl = min(vl, VLEN/SEW) at capture; vl above VLEN/SEW is clamped, not rejected.
REQ-020 SHALL initialise the accumulator to vs1_scalar[SEW-1:0] and the element index to 0 on capture.
REQ-021 In RUN, each beat SHALL combine elements index through index+NB_LANES-1 into the accumulator, in one cycle.
REQ-022 Within a beat, an element SHALL be skipped (identity) if its index >= eff_vl, or if vm=0 and v0[index]=0.
REQ-023 Arithmetic SHALL be carried out at SEW width:
- sum wraps modulo 2^SEW;
- min and max compare as two's-complement at SEW;
- minu and maxu compare unsigned.
REQ-024 After each beat, index SHALL advance by NB_LANES.
REQ-025 RUN SHALL exit to FIN after the beat in which index+NB_LANES >= eff_vl.
REQ-026 RUN therefore SHALL last ceil(eff_vl/NB_LANES) cycles, and done SHALL rise exactly that many cycles plus 1 after the start cycle.
REQ-027 If eff_vl = 0, SHALL go directly from IDLE to FIN; done rises 1 cycle after start and result = vs1_scalar[SEW-1:0].
REQ-028 If vsew is invalid, SHALL go directly to FIN; done rises 1 cycle after start with result = 0 and instr_valid = 0.
REQ-029 In FIN, SHALL drive done=1 for exactly one cycle, update result and instr_valid, clear busy, and return to IDLE.
REQ-030 A start in the FIN cycle SHALL be ignored; a start in the cycle after done SHALL be accepted.
REQ-031 result and instr_valid SHALL hold their values until the next FIN.
REQ-032 Input changes after the capture cycle SHALL NOT affect the operation in flight.
REQ-033 If all elements are masked off, result SHALL equal vs1_scalar[SEW-1:0].
REQ-034 The element index register SHALL be 17 bits so that VLEN=65536 with SEW=8 does not overflow.

Reset
REQ-035 While resetn=0, the following SHALL be forced asynchronously: state = IDLE, busy = 0, done = 0, result = 0, instr_valid = 0, accumulator = 0, index = 0.
REQ-036 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-037 NB_LANES=4, SEW=8, vl=16, vs2 elements 1..16, vs1=5, funct=sum -> 4 RUN beats, done 5 cycles after start, result=0x8D.
REQ-038 SEW=32, vl=4, vs2 = {0xFFFFFFFF, 3, 0x80000000, 7}, vs1=0:
- funct=min -> result=0x80000000;
- funct=minu -> result=0;
- funct=max -> result=7.
REQ-039 SEW=16, vl=8, vm=0, v0=0x00 -> result equals vs1=0x1234 for every funct; vm=0, v0=0x05, funct=or on elements {0x0001, 0x0002, 0x0004, ...} with vs1=0 -> result=0x0005.
REQ-040 vl=0 -> done 1 cycle after start, result=vs1 low SEW bits; vsew=011 -> done 1 cycle after start, result=0, instr_valid=0.
REQ-041 VLEN=128, SEW=8, vl=200 -> clamped to 16 elements, identical result to vl=16; a second start asserted during RUN is ignored and busy stays high.
REQ-042 resetn pulsed low in the 2nd RUN cycle -> busy=0 and done never pulses; a new start with sum over vl=4 of ones and vs1=0 -> result=4.
